// File: rtl/iomem_initiator.sv
// iomem bus master: one cmd -> one iomem transaction -> one response (read data or timeout error).
// Latency: 1-cycle responder gives rsp_valid 3 cycles after accept; no command accepted until response consumed.
module iomem_initiator #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_bufg,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_iomem_valid, w_iomem_valid_nxt;
  logic [31:0] r_iomem_addr, w_iomem_addr_nxt;
  logic [31:0] r_iomem_wdata, w_iomem_wdata_nxt;
  logic [3:0]  r_iomem_wstrb, w_iomem_wstrb_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [31:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic        r_rsp_err, w_rsp_err_nxt;
  logic        r_busy, w_busy_nxt;

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_iomem_valid_nxt = r_iomem_valid;
    w_iomem_addr_nxt  = r_iomem_addr;
    w_iomem_wdata_nxt = r_iomem_wdata;
    w_iomem_wstrb_nxt = r_iomem_wstrb;
    w_rsp_valid_nxt   = r_rsp_valid;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_rsp_err_nxt     = r_rsp_err;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_iomem_addr_nxt  = cmd_addr;
          w_iomem_wdata_nxt = cmd_wdata;
          w_iomem_wstrb_nxt = cmd_wstrb;
          w_iomem_valid_nxt = 1'b1;
          w_cnt_nxt         = '0;
          w_state_nxt       = ST_REQ;
        end
      end
      ST_REQ: begin
        w_cnt_nxt = r_cnt + 16'd1;
        // A completion on the final allowed cycle still counts as success.
        if (iomem_ready) begin
          w_rsp_rdata_nxt   = iomem_rdata;
          w_rsp_err_nxt     = 1'b0;
          w_iomem_valid_nxt = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RSP;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_rsp_rdata_nxt   = ERR_DATA;
          w_rsp_err_nxt     = 1'b1;
          w_iomem_valid_nxt = 1'b0;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RSP;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_bufg) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_iomem_valid <= 1'b0;
      r_iomem_addr  <= '0;
      r_iomem_wdata <= '0;
      r_iomem_wstrb <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_iomem_valid <= w_iomem_valid_nxt;
      r_iomem_addr  <= w_iomem_addr_nxt;
      r_iomem_wdata <= w_iomem_wdata_nxt;
      r_iomem_wstrb <= w_iomem_wstrb_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_err     <= w_rsp_err_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign iomem_valid = r_iomem_valid;
  assign iomem_addr  = r_iomem_addr;
  assign iomem_wdata = r_iomem_wdata;
  assign iomem_wstrb = r_iomem_wstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;

endmodule
